// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift left/right, parallel load, serial I/O both ends.
// Saturating shift counter with done flag. Define USHREG_ROTATE_EN to make both shift modes rotate.
module universal_shift_reg #(
    parameter int unsigned            WIDTH     = 8,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    mode_t            mode_e;
    logic [WIDTH-1:0] reg_d, reg_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] shl_val, shr_val;
    logic [CW-1:0]    cnt_next;

    assign mode_e = mode_t'(mode);

`ifdef USHREG_ROTATE_EN
    logic unused_sin;
    assign unused_sin = sin_l ^ sin_r;
    assign shl_val    = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
    assign shr_val    = {reg_q[0], reg_q[WIDTH-1:1]};
`else
    assign shl_val    = {reg_q[WIDTH-2:0], sin_r};
    assign shr_val    = {sin_l, reg_q[WIDTH-1:1]};
`endif

    // Counter tracks shift operations regardless of direction and sticks at WIDTH.
    assign cnt_next = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        reg_d = reg_q;
        cnt_d = cnt_q;
        if (en) begin
            case (mode_e)
                MODE_HOLD: begin
                    reg_d = reg_q;
                    cnt_d = cnt_q;
                end
                MODE_SHL: begin
                    reg_d = shl_val;
                    cnt_d = cnt_next;
                end
                MODE_SHR: begin
                    reg_d = shr_val;
                    cnt_d = cnt_next;
                end
                MODE_LOAD: begin
                    reg_d = d;
                    cnt_d = '0;
                end
                default: begin
                    reg_d = reg_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_q <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            reg_q <= reg_d;
            cnt_q <= cnt_d;
        end
    end

    assign q         = reg_q;
    assign sout_l    = reg_q[WIDTH-1];
    assign sout_r    = reg_q[0];
    assign shift_cnt = cnt_q;
    assign done      = (cnt_q == CW'(WIDTH));

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, RESET_VAL=0).
// Shift-with-serial-input scenarios run in the default build; rotate scenarios with USHREG_ROTATE_EN.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] shift_cnt;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    universal_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        rst = 1'b1; en = 1'b1; mode = 2'b11; d = val;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF; sin_l = 1'b1; sin_r = 1'b1;
        tick();
        vectors++; if (q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h want 00", q); end
        vectors++; if (shift_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if ({sout_l, sout_r} !== 2'b00) begin miscompares++; $display("FAIL reset_sout: got %b want 00", {sout_l, sout_r}); end
    endtask

    task automatic test_load();
        load(8'hA5);
        vectors++; if (q !== 8'hA5) begin miscompares++; $display("FAIL load_q: got %h want a5", q); end
        vectors++; if ({sout_l, sout_r} !== 2'b11) begin miscompares++; $display("FAIL load_sout: got %b want 11", {sout_l, sout_r}); end
        vectors++; if (shift_cnt !== 4'd0) begin miscompares++; $display("FAIL load_cnt: got %0d want 0", shift_cnt); end
    endtask

    task automatic test_enable_hold();
        load(8'h5A);
        en = 1'b0; mode = 2'b11; d = 8'h3C;
        repeat (3) tick();
        vectors++; if (q !== 8'h5A) begin miscompares++; $display("FAIL en_hold_load_q: got %h want 5a", q); end
        en = 1'b0; mode = 2'b01; sin_r = 1'b1;
        repeat (2) tick();
        vectors++; if (q !== 8'h5A) begin miscompares++; $display("FAIL en_hold_shift_q: got %h want 5a", q); end
        vectors++; if (shift_cnt !== 4'd0) begin miscompares++; $display("FAIL en_hold_cnt: got %0d want 0", shift_cnt); end
        en = 1'b1; mode = 2'b00; d = 8'hFF;
        tick();
        vectors++; if (q !== 8'h5A || shift_cnt !== 4'd0) begin miscompares++; $display("FAIL mode_hold: got q=%h cnt=%0d want q=5a cnt=0", q, shift_cnt); end
    endtask

    task automatic test_between_edges();
        load(8'h3C);
        mode = 2'b11; d = 8'hAA; sin_l = 1'b0; sin_r = 1'b0;
        #2;
        vectors++; if (q !== 8'h3C) begin miscompares++; $display("FAIL comb_path_q: got %h want 3c", q); end
        mode = 2'b00;
        tick();
        vectors++; if (q !== 8'h3C) begin miscompares++; $display("FAIL edge_sample_q: got %h want 3c", q); end
    endtask

    task automatic test_reset_priority();
        load(8'h5A);
        en = 1'b1; mode = 2'b01; sin_r = 1'b0;
        repeat (2) tick();
        vectors++; if (q !== 8'h68 || shift_cnt !== 4'd2) begin miscompares++; $display("FAIL pre_abort: got q=%h cnt=%0d want q=68 cnt=2", q, shift_cnt); end
        rst = 1'b0;
        tick();
        vectors++; if (q !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_reset: got q=%h cnt=%0d done=%b want q=00 cnt=0 done=0", q, shift_cnt, done); end
        rst = 1'b1; en = 1'b0;
        tick();
        vectors++; if (q !== 8'h00 || shift_cnt !== 4'd0) begin miscompares++; $display("FAIL abort_residue: got q=%h cnt=%0d want q=00 cnt=0", q, shift_cnt); end
    endtask

`ifndef USHREG_ROTATE_EN
    task automatic test_shift_left();
        load(8'hA5);
        mode = 2'b01; sin_r = 1'b0; sin_l = 1'b1;
        tick();
        vectors++; if (q !== 8'h4A) begin miscompares++; $display("FAIL shl_q: got %h want 4a", q); end
        vectors++; if (sout_l !== 1'b0) begin miscompares++; $display("FAIL shl_sout_l: got %b want 0", sout_l); end
        vectors++; if (shift_cnt !== 4'd1 || done !== 1'b0) begin miscompares++; $display("FAIL shl_cnt: got cnt=%0d done=%b want cnt=1 done=0", shift_cnt, done); end
    endtask

    task automatic test_shift_right();
        load(8'hA5);
        mode = 2'b10; sin_l = 1'b1; sin_r = 1'b1;
        tick();
        vectors++; if (q !== 8'hD2) begin miscompares++; $display("FAIL shr_q: got %h want d2", q); end
        vectors++; if (sout_r !== 1'b0) begin miscompares++; $display("FAIL shr_sout_r: got %b want 0", sout_r); end
        vectors++; if (shift_cnt !== 4'd1) begin miscompares++; $display("FAIL shr_cnt: got %0d want 1", shift_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_q;
        load(8'h00);
        mode = 2'b01; sin_r = 1'b1; sin_l = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_q = 8'((16'd1 << k) - 16'd1);
            vectors++;
            if (q !== exp_q || shift_cnt !== 4'(k) || done !== (k == 8)) begin
                miscompares++;
                $display("FAIL sat_step%0d: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b", k, q, shift_cnt, done, exp_q, k, (k == 8));
            end
        end
        sin_r = 1'b0;
        tick();
        vectors++; if (q !== 8'hFE || shift_cnt !== 4'd8 || done !== 1'b1) begin miscompares++; $display("FAIL sat_9th: got q=%h cnt=%0d done=%b want q=fe cnt=8 done=1", q, shift_cnt, done); end
        mode = 2'b10; sin_l = 1'b0;
        tick();
        vectors++; if (q !== 8'h7F || shift_cnt !== 4'd8 || done !== 1'b1) begin miscompares++; $display("FAIL sat_10th: got q=%h cnt=%0d done=%b want q=7f cnt=8 done=1", q, shift_cnt, done); end
        load(8'h12);
        vectors++; if (q !== 8'h12 || shift_cnt !== 4'd0 || done !== 1'b0) begin miscompares++; $display("FAIL sat_reload: got q=%h cnt=%0d done=%b want q=12 cnt=0 done=0", q, shift_cnt, done); end
    endtask

    task automatic test_direction_mix();
        load(8'h81);
        mode = 2'b01; sin_r = 1'b0;
        tick();
        vectors++; if (q !== 8'h02) begin miscompares++; $display("FAIL mix_left1: got %h want 02", q); end
        mode = 2'b10; sin_l = 1'b0;
        tick();
        vectors++; if (q !== 8'h01) begin miscompares++; $display("FAIL mix_right: got %h want 01", q); end
        mode = 2'b01; sin_r = 1'b1;
        tick();
        vectors++; if (q !== 8'h03 || shift_cnt !== 4'd3) begin miscompares++; $display("FAIL mix_left2: got q=%h cnt=%0d want q=03 cnt=3", q, shift_cnt); end
    endtask
`else
    task automatic test_rotate();
        load(8'hA5);
        mode = 2'b01; sin_r = 1'b0; sin_l = 1'b0;
        tick();
        vectors++; if (q !== 8'h4B || shift_cnt !== 4'd1) begin miscompares++; $display("FAIL rotl: got q=%h cnt=%0d want q=4b cnt=1", q, shift_cnt); end
        mode = 2'b10; sin_l = 1'b0;
        tick();
        vectors++; if (q !== 8'hA5 || shift_cnt !== 4'd2) begin miscompares++; $display("FAIL rotr: got q=%h cnt=%0d want q=a5 cnt=2", q, shift_cnt); end
        load(8'h81);
        mode = 2'b01; sin_r = 1'b0;
        repeat (8) tick();
        vectors++; if (q !== 8'h81 || shift_cnt !== 4'd8 || done !== 1'b1) begin miscompares++; $display("FAIL rot_full: got q=%h cnt=%0d done=%b want q=81 cnt=8 done=1", q, shift_cnt, done); end
        mode = 2'b10; sin_l = 1'b0;
        tick();
        vectors++; if (q !== 8'hC0 || shift_cnt !== 4'd8) begin miscompares++; $display("FAIL rot_sat: got q=%h cnt=%0d want q=c0 cnt=8", q, shift_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        test_reset();
        test_load();
`ifndef USHREG_ROTATE_EN
        test_shift_left();
        test_shift_right();
        test_saturation();
        test_direction_mix();
`else
        test_rotate();
`endif
        test_enable_hold();
        test_between_edges();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
